// File: rtl/cu_read_data_pair_merge_pkg.sv
// Shared types and constants for the read-data pair merge block.
// The optional CU_READ_MERGE_PERF_EN build adds performance counters to the top.
package cu_read_data_pair_merge_pkg;
  localparam int DATA_W         = 512;
  localparam int TAG_W          = 8;
  localparam int CU_ID_W        = 8;
  localparam int SLOT_IDX_W     = 5;
  localparam int NUM_SLOTS      = 1 << SLOT_IDX_W;
  localparam int ALMOST_FULL_TH = 28;
  localparam logic [7:0] RESP_DONE = 8'h00;

  typedef struct packed {
    logic h0;
    logic h1;
    logic rsp;
    logic err;
  } slot_flags_t;

  typedef struct packed {
    slot_flags_t             flags;
    logic [CU_ID_W-1:0]      cu_id;
    logic [TAG_W-1:0]        tag;
    logic [2*DATA_W-1:0]     data;
  } merge_slot_t;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic [CU_ID_W-1:0]      cu_id;
    logic [2*DATA_W-1:0]     data;
    logic                    error;
  } merged_line_t;

  function automatic logic slot_allocated(slot_flags_t f);
    return f.h0 | f.h1 | f.rsp;
  endfunction

  // A failed response finishes the line even if halves are still missing.
  function automatic logic slot_complete(slot_flags_t f);
    return (f.h0 & f.h1 & f.rsp) | (f.rsp & f.err);
  endfunction

  function automatic logic tag_clash(merge_slot_t s, logic [TAG_W-1:0] tag);
    return slot_allocated(s.flags) && (s.tag != tag);
  endfunction
endpackage

// File: rtl/cu_read_data_pair_merge_if.sv
// Input half-line/response streams and merged-line output port.
// Inputs carry a valid only (cannot be stalled); the output uses valid/ready:
// a beat transfers on a clock edge where out_valid & out_ready, and out_* hold while out_valid & !out_ready.
interface cu_read_data_pair_merge_if;
  import cu_read_data_pair_merge_pkg::*;

  logic                  data_0_valid;
  logic [TAG_W-1:0]      data_0_tag;
  logic [CU_ID_W-1:0]    data_0_cu_id;
  logic [DATA_W-1:0]     data_0_data;
  logic                  data_1_valid;
  logic [TAG_W-1:0]      data_1_tag;
  logic [DATA_W-1:0]     data_1_data;
  logic                  resp_valid;
  logic [TAG_W-1:0]      resp_tag;
  logic [7:0]            resp_code;
  logic                  out_valid;
  logic                  out_ready;
  logic [TAG_W-1:0]      out_tag;
  logic [CU_ID_W-1:0]    out_cu_id;
  logic [2*DATA_W-1:0]   out_data;
  logic                  out_error;

  modport master (
    output data_0_valid, data_0_tag, data_0_cu_id, data_0_data,
    output data_1_valid, data_1_tag, data_1_data,
    output resp_valid, resp_tag, resp_code, out_ready,
    input  out_valid, out_tag, out_cu_id, out_data, out_error
  );

  modport slave (
    input  data_0_valid, data_0_tag, data_0_cu_id, data_0_data,
    input  data_1_valid, data_1_tag, data_1_data,
    input  resp_valid, resp_tag, resp_code, out_ready,
    output out_valid, out_tag, out_cu_id, out_data, out_error
  );
endinterface

// File: rtl/cu_read_merge_slot_picker.sv
// Lowest-index priority encoder over the per-slot complete vector.
module cu_read_merge_slot_picker #(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  logic [N-1:0]     complete,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (complete[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cu_read_data_pair_merge.sv
// Joins two half-lines and a response per tag into one 1024-bit line, emitted over valid/ready.
// Define CU_READ_MERGE_PERF_EN to add perf_lines_merged / perf_error_lines / perf_stall_cycles.
module cu_read_data_pair_merge
  import cu_read_data_pair_merge_pkg::*;
(
  input  logic                  clock,
  input  logic                  rst_in,
  input  logic                  enabled_in,
  cu_read_data_pair_merge_if.slave bus,
  output logic                  almost_full,
  output logic                  collision_err,
  output logic [SLOT_IDX_W:0]   occupied_count
`ifdef CU_READ_MERGE_PERF_EN
  ,
  output logic [31:0]           perf_lines_merged,
  output logic [31:0]           perf_error_lines,
  output logic [31:0]           perf_stall_cycles
`endif
);
  logic                   enabled_q;
  slot_flags_t            flags_q  [NUM_SLOTS];
  logic [CU_ID_W-1:0]     cu_id_q  [NUM_SLOTS];
  logic [TAG_W-1:0]       tag_q    [NUM_SLOTS];
  logic [2*DATA_W-1:0]    data_q   [NUM_SLOTS];
  merge_slot_t            slots_cur[NUM_SLOTS];
  merge_slot_t            slots_n  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   complete;
  logic [SLOT_IDX_W-1:0]  pick_idx, i0, i1, ir;
  logic                   pick_found, load, collision;
  logic [SLOT_IDX_W:0]    count_n;
  merged_line_t           line_sel, out_q;
  logic                   out_valid_q;

  assign i0 = bus.data_0_tag[SLOT_IDX_W-1:0];
  assign i1 = bus.data_1_tag[SLOT_IDX_W-1:0];
  assign ir = bus.resp_tag[SLOT_IDX_W-1:0];

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slots_cur[i] = '{flags: flags_q[i], cu_id: cu_id_q[i], tag: tag_q[i], data: data_q[i]};
      complete[i]  = slot_complete(flags_q[i]);
    end
  end

  cu_read_merge_slot_picker #(.N(NUM_SLOTS), .IDX_W(SLOT_IDX_W)) u_picker (
    .complete (complete),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  // The picked slot is freed before inputs are applied, so a late half
  // arriving on the emitting edge re-allocates the slot instead of colliding.
  always_comb begin
    slots_n   = slots_cur;
    load      = 1'b0;
    collision = 1'b0;
    if (enabled_q) begin
      load = pick_found && (!out_valid_q || bus.out_ready);
      if (load) slots_n[pick_idx].flags = '0;
      if (bus.data_0_valid) begin
        if (slots_n[i0].flags.h0 || tag_clash(slots_n[i0], bus.data_0_tag)) collision = 1'b1;
        else begin
          slots_n[i0].flags.h0           = 1'b1;
          slots_n[i0].tag                = bus.data_0_tag;
          slots_n[i0].cu_id              = bus.data_0_cu_id;
          slots_n[i0].data[DATA_W-1:0]   = bus.data_0_data;
        end
      end
      if (bus.data_1_valid) begin
        if (slots_n[i1].flags.h1 || tag_clash(slots_n[i1], bus.data_1_tag)) collision = 1'b1;
        else begin
          slots_n[i1].flags.h1               = 1'b1;
          slots_n[i1].tag                    = bus.data_1_tag;
          slots_n[i1].data[2*DATA_W-1:DATA_W] = bus.data_1_data;
        end
      end
      if (bus.resp_valid) begin
        if (slots_n[ir].flags.rsp || tag_clash(slots_n[ir], bus.resp_tag)) collision = 1'b1;
        else begin
          slots_n[ir].flags.rsp = 1'b1;
          slots_n[ir].flags.err = (bus.resp_code != RESP_DONE);
          slots_n[ir].tag       = bus.resp_tag;
        end
      end
    end
  end

  always_comb begin
    count_n = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      count_n = count_n + (SLOT_IDX_W + 1)'(slot_allocated(slots_n[i].flags));
  end

  always_comb begin
    line_sel.tag   = slots_cur[pick_idx].tag;
    line_sel.cu_id = slots_cur[pick_idx].cu_id;
    line_sel.error = slots_cur[pick_idx].flags.err;
    line_sel.data  = slots_cur[pick_idx].flags.err ? '0 : slots_cur[pick_idx].data;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cu_id_q[i] <= slots_n[i].cu_id;
      tag_q[i]   <= slots_n[i].tag;
      data_q[i]  <= slots_n[i].data;
    end
  end

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      enabled_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_q          <= '0;
      collision_err  <= 1'b0;
      occupied_count <= '0;
      almost_full    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) flags_q[i] <= '0;
    end else begin
      enabled_q      <= enabled_in;
      occupied_count <= count_n;
      almost_full    <= (occupied_count >= (SLOT_IDX_W + 1)'(ALMOST_FULL_TH));
      for (int i = 0; i < NUM_SLOTS; i++) flags_q[i] <= slots_n[i].flags;
      if (collision) collision_err <= 1'b1;
      if (enabled_q) begin
        if (load) begin
          out_valid_q <= 1'b1;
          out_q       <= line_sel;
        end else if (bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_q.tag;
  assign bus.out_cu_id = out_q.cu_id;
  assign bus.out_data  = out_q.data;
  assign bus.out_error = out_q.error;

`ifdef CU_READ_MERGE_PERF_EN
  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      perf_lines_merged <= '0;
      perf_error_lines  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (enabled_q && out_valid_q && bus.out_ready) begin
        perf_lines_merged <= perf_lines_merged + 32'd1;
        if (out_q.error) perf_error_lines <= perf_error_lines + 32'd1;
      end
      if (out_valid_q && !bus.out_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cu_read_data_pair_merge.sv
// Directed bench for cu_read_data_pair_merge: per-scenario tasks with inline checks.
module tb_cu_read_data_pair_merge;
  import cu_read_data_pair_merge_pkg::*;

  logic clock = 1'b0;
  logic rst_in = 1'b1;
  logic enabled_in = 1'b0;
  logic almost_full, collision_err;
  logic [SLOT_IDX_W:0] occupied_count;
  int vectors = 0;
  int miscompares = 0;
`ifdef CU_READ_MERGE_PERF_EN
  logic [31:0] perf_lines_merged, perf_error_lines, perf_stall_cycles;
`endif

  cu_read_data_pair_merge_if bus();

  cu_read_data_pair_merge dut (
    .clock          (clock),
    .rst_in         (rst_in),
    .enabled_in     (enabled_in),
    .bus            (bus),
    .almost_full    (almost_full),
    .collision_err  (collision_err),
    .occupied_count (occupied_count)
`ifdef CU_READ_MERGE_PERF_EN
    ,
    .perf_lines_merged (perf_lines_merged),
    .perf_error_lines  (perf_error_lines),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_0_valid = 1'b0; bus.data_0_tag = '0; bus.data_0_cu_id = '0; bus.data_0_data = '0;
    bus.data_1_valid = 1'b0; bus.data_1_tag = '0; bus.data_1_data = '0;
    bus.resp_valid   = 1'b0; bus.resp_tag   = '0; bus.resp_code   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    rst_in = 1'b1;
    tick(); tick();
    vectors++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); miscompares++; end
    vectors++; if (occupied_count !== 6'd0) begin $display("FAIL reset_occ got=%0d exp=0", occupied_count); miscompares++; end
    vectors++; if (almost_full !== 1'b0 || collision_err !== 1'b0) begin $display("FAIL reset_flags af=%b ce=%b exp=0,0", almost_full, collision_err); miscompares++; end
    rst_in = 1'b0;
    enabled_in = 1'b1;
    tick();
  endtask

  task automatic test_full_line();
    logic [DATA_W-1:0] d0, d1;
    logic [2*DATA_W-1:0] exp_line;
    d0 = {16{32'h0A0A_0005}};
    d1 = {16{32'h1B1B_0005}};
    exp_line = {d1, d0};
    bus.data_0_valid = 1'b1; bus.data_0_tag = 8'h05; bus.data_0_cu_id = 8'h11; bus.data_0_data = d0;
    tick(); idle_inputs();
    vectors++; if (occupied_count !== 6'd1) begin $display("FAIL full_occ_alloc got=%0d exp=1", occupied_count); miscompares++; end
    bus.data_1_valid = 1'b1; bus.data_1_tag = 8'h05; bus.data_1_data = d1;
    tick(); idle_inputs();
    bus.resp_valid = 1'b1; bus.resp_tag = 8'h05; bus.resp_code = RESP_DONE;
    tick(); idle_inputs();
    vectors++; if (bus.out_valid !== 1'b0) begin $display("FAIL full_early_valid got=%b exp=0", bus.out_valid); miscompares++; end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'h05 || bus.out_cu_id !== 8'h11 || bus.out_error !== 1'b0)
      begin $display("FAIL full_hdr got v=%b tag=%h cu=%h err=%b exp 1,05,11,0", bus.out_valid, bus.out_tag, bus.out_cu_id, bus.out_error); miscompares++; end
    vectors++; if (bus.out_data !== exp_line) begin $display("FAIL full_data got_lo=%h got_hi=%h exp_lo=%h exp_hi=%h", bus.out_data[63:0], bus.out_data[1023:960], exp_line[63:0], exp_line[1023:960]); miscompares++; end
    vectors++; if (occupied_count !== 6'd0) begin $display("FAIL full_occ_free got=%0d exp=0", occupied_count); miscompares++; end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin $display("FAIL full_drain got=%b exp=0", bus.out_valid); miscompares++; end
  endtask

  task automatic test_error_line();
    bus.resp_valid = 1'b1; bus.resp_tag = 8'h03; bus.resp_code = 8'h0A;
    tick(); idle_inputs();
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_error !== 1'b1 || bus.out_tag !== 8'h03)
      begin $display("FAIL err_hdr got v=%b err=%b tag=%h exp 1,1,03", bus.out_valid, bus.out_error, bus.out_tag); miscompares++; end
    vectors++; if (bus.out_data !== '0) begin $display("FAIL err_data got_lo=%h exp=0", bus.out_data[63:0]); miscompares++; end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d0a, d1a, d0b, d1b;
    d0a = {16{32'h2000_00A0}}; d1a = {16{32'h2100_00A1}};
    d0b = {16{32'h7000_00B0}}; d1b = {16{32'h7100_00B1}};
    bus.data_1_valid = 1'b1; bus.data_1_tag = 8'h02; bus.data_1_data = d1a;
    bus.data_0_valid = 1'b1; bus.data_0_tag = 8'h07; bus.data_0_cu_id = 8'h77; bus.data_0_data = d0b;
    tick(); idle_inputs();
    bus.resp_valid = 1'b1; bus.resp_tag = 8'h02; bus.resp_code = RESP_DONE;
    tick(); idle_inputs();
    bus.resp_valid = 1'b1; bus.resp_tag = 8'h07; bus.resp_code = RESP_DONE;
    tick(); idle_inputs();
    vectors++; if (occupied_count !== 6'd2) begin $display("FAIL b2b_occ got=%0d exp=2", occupied_count); miscompares++; end
    bus.data_0_valid = 1'b1; bus.data_0_tag = 8'h02; bus.data_0_cu_id = 8'h22; bus.data_0_data = d0a;
    bus.data_1_valid = 1'b1; bus.data_1_tag = 8'h07; bus.data_1_data = d1b;
    tick(); idle_inputs();
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'h02 || bus.out_cu_id !== 8'h22 || bus.out_data !== {d1a, d0a})
      begin $display("FAIL b2b_first got v=%b tag=%h cu=%h lo=%h exp 1,02,22,%h", bus.out_valid, bus.out_tag, bus.out_cu_id, bus.out_data[63:0], d0a[63:0]); miscompares++; end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'h07 || bus.out_cu_id !== 8'h77 || bus.out_data !== {d1b, d0b})
      begin $display("FAIL b2b_second got v=%b tag=%h cu=%h lo=%h exp 1,07,77,%h", bus.out_valid, bus.out_tag, bus.out_cu_id, bus.out_data[63:0], d0b[63:0]); miscompares++; end
    vectors++; if (occupied_count !== 6'd0) begin $display("FAIL b2b_occ_end got=%0d exp=0", occupied_count); miscompares++; end
    tick();
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] d0, d1;
    d0 = {16{32'h9000_0009}}; d1 = {16{32'h9100_0009}};
    bus.out_ready = 1'b0;
    bus.data_0_valid = 1'b1; bus.data_0_tag = 8'h09; bus.data_0_cu_id = 8'h99; bus.data_0_data = d0;
    bus.data_1_valid = 1'b1; bus.data_1_tag = 8'h09; bus.data_1_data = d1;
    bus.resp_valid = 1'b1; bus.resp_tag = 8'h09; bus.resp_code = RESP_DONE;
    tick(); idle_inputs();
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 8'h09 || bus.out_cu_id !== 8'h99 || bus.out_data !== {d1, d0})
        begin $display("FAIL stall_hold cyc=%0d got v=%b tag=%h cu=%h lo=%h exp 1,09,99,%h", c, bus.out_valid, bus.out_tag, bus.out_cu_id, bus.out_data[63:0], d0[63:0]); miscompares++; end
    end
`ifdef CU_READ_MERGE_PERF_EN
    vectors++; if (perf_stall_cycles !== 32'd5) begin $display("FAIL perf_stall got=%0d exp=5", perf_stall_cycles); miscompares++; end
`endif
    bus.out_ready = 1'b1;
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin $display("FAIL stall_release got=%b exp=0", bus.out_valid); miscompares++; end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] d0x, d0y, d1x;
    d0x = {16{32'h4000_0044}}; d0y = {16{32'hDEAD_BEEF}}; d1x = {16{32'h4100_0044}};
    bus.data_0_valid = 1'b1; bus.data_0_tag = 8'h04; bus.data_0_cu_id = 8'h44; bus.data_0_data = d0x;
    tick(); idle_inputs();
    vectors++; if (collision_err !== 1'b0) begin $display("FAIL coll_pre got=%b exp=0", collision_err); miscompares++; end
    bus.data_0_valid = 1'b1; bus.data_0_tag = 8'h04; bus.data_0_cu_id = 8'hEE; bus.data_0_data = d0y;
    tick(); idle_inputs();
    vectors++; if (collision_err !== 1'b1) begin $display("FAIL coll_set got=%b exp=1", collision_err); miscompares++; end
    bus.data_1_valid = 1'b1; bus.data_1_tag = 8'h04; bus.data_1_data = d1x;
    tick(); idle_inputs();
    bus.resp_valid = 1'b1; bus.resp_tag = 8'h04; bus.resp_code = RESP_DONE;
    tick(); idle_inputs();
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_cu_id !== 8'h44 || bus.out_data !== {d1x, d0x})
      begin $display("FAIL coll_orig got v=%b cu=%h lo=%h exp 1,44,%h", bus.out_valid, bus.out_cu_id, bus.out_data[63:0], d0x[63:0]); miscompares++; end
    tick();
    vectors++; if (collision_err !== 1'b1) begin $display("FAIL coll_sticky got=%b exp=1", collision_err); miscompares++; end
  endtask

  task automatic test_disabled();
    enabled_in = 1'b0;
    tick();
    bus.data_0_valid = 1'b1; bus.data_0_tag = 8'h01; bus.data_0_cu_id = 8'h01; bus.data_0_data = '1;
    tick(); idle_inputs();
    vectors++; if (occupied_count !== 6'd0) begin $display("FAIL dis_ignore got=%0d exp=0", occupied_count); miscompares++; end
    enabled_in = 1'b1;
    tick();
  endtask

  task automatic test_almost_full_and_reset();
    for (int t = 0; t < 28; t++) begin
      bus.data_0_valid = 1'b1; bus.data_0_tag = 8'(t); bus.data_0_cu_id = 8'h30; bus.data_0_data = 512'(t);
      tick();
    end
    idle_inputs();
    vectors++; if (occupied_count !== 6'd28 || almost_full !== 1'b0) begin $display("FAIL af_edge occ=%0d af=%b exp 28,0", occupied_count, almost_full); miscompares++; end
    bus.out_ready = 1'b0;
    tick();
    vectors++; if (almost_full !== 1'b1) begin $display("FAIL af_set got=%b exp=1", almost_full); miscompares++; end
    bus.resp_valid = 1'b1; bus.resp_tag = 8'h00; bus.resp_code = 8'h05;
    tick(); idle_inputs();
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_error !== 1'b1 || occupied_count !== 6'd27)
      begin $display("FAIL af_pending got v=%b err=%b occ=%0d exp 1,1,27", bus.out_valid, bus.out_error, occupied_count); miscompares++; end
    #2 rst_in = 1'b1;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.out_error !== 1'b0 || bus.out_tag !== 8'h00 || bus.out_data !== '0)
      begin $display("FAIL rst_mid_out got v=%b err=%b tag=%h exp 0,0,00", bus.out_valid, bus.out_error, bus.out_tag); miscompares++; end
    vectors++; if (occupied_count !== 6'd0 || almost_full !== 1'b0 || collision_err !== 1'b0)
      begin $display("FAIL rst_mid_state occ=%0d af=%b ce=%b exp 0,0,0", occupied_count, almost_full, collision_err); miscompares++; end
    tick();
    rst_in = 1'b0;
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    vectors++; if (bus.out_valid !== 1'b0 || occupied_count !== 6'd0)
      begin $display("FAIL rst_discard v=%b occ=%0d exp 0,0", bus.out_valid, occupied_count); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_error_line();
    test_back_to_back();
    test_stall();
    test_collision();
    test_disabled();
    test_almost_full_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
